// File: rtl/rom_port_arbiter.sv
// Single-port program SRAM arbiter: CPU byte fetch vs. Wishbone word access, one access in flight.
// Define ROM_FETCH_CACHE_EN to add a one-word fetch buffer in front of the CPU path.
module rom_port_arbiter #(
  parameter int ADDR_W        = 9,
  parameter int WB_STARVE_MAX = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cpu_req,
  input  logic [ADDR_W+1:0] cpu_addr,
  output logic [7:0]        cpu_data,
  output logic              cpu_valid,
  input  logic              wbs_sel,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              sram_csb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_din,
  input  logic [31:0]       sram_dout
);
  localparam int CW = $clog2(WB_STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(WB_STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t            state, state_nx;
  logic              sel_wb, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic [1:0]        lane_q;
  logic [CW-1:0]     starve_cnt;
  logic              wb_pend, grant_wb, grant_cpu, hit;
  logic [7:0]        hit_byte;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] l);
    case (l)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  assign wb_pend   = wbs_cyc_i & wbs_stb_i & wbs_sel;
  assign grant_wb  = (state == IDLE) && wb_pend && (!cpu_req || starve_cnt == STARVE_MAX);
  assign grant_cpu = (state == IDLE) && cpu_req && !grant_wb;

`ifdef ROM_FETCH_CACHE_EN
  logic [31:0]       buf_data;
  logic [ADDR_W-1:0] buf_tag;
  logic              buf_vld;

  assign hit      = grant_cpu && buf_vld && (buf_tag == cpu_addr[ADDR_W+1:2]);
  assign hit_byte = lane_byte(buf_data, cpu_addr[1:0]);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      buf_vld  <= 1'b0;
      buf_tag  <= '0;
      buf_data <= '0;
    end else if (state == CAPTURE && !sel_wb) begin
      buf_vld  <= 1'b1;
      buf_tag  <= addr_q;
      buf_data <= sram_dout;
    end else if (grant_wb && wbs_we_i && buf_vld && buf_tag == wbs_adr_i) begin
      buf_vld  <= 1'b0;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_byte = 8'h00;
`endif

  always_comb begin
    state_nx  = state;
    cpu_valid = 1'b0;
    wbs_ack_o = 1'b0;
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    case (state)
      IDLE:    if (grant_wb || grant_cpu) state_nx = hit ? RESP : ACCESS;
      ACCESS: begin
        state_nx = CAPTURE;
        sram_csb = 1'b0;
        sram_web = ~we_q;
      end
      CAPTURE: state_nx = RESP;
      RESP: begin
        state_nx  = IDLE;
        cpu_valid = ~sel_wb;
        wbs_ack_o = sel_wb;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sram_addr = addr_q;
  assign sram_din  = din_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      sel_wb     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      lane_q     <= '0;
      starve_cnt <= '0;
      cpu_data   <= '0;
      wbs_dat_o  <= '0;
    end else begin
      state <= state_nx;
      if (grant_wb) begin
        sel_wb <= 1'b1;
        we_q   <= wbs_we_i;
        addr_q <= wbs_adr_i;
        din_q  <= wbs_dat_i;
      end else if (grant_cpu) begin
        sel_wb <= 1'b0;
        we_q   <= 1'b0;
        lane_q <= cpu_addr[1:0];
        if (!hit) addr_q <= cpu_addr[ADDR_W+1:2];
      end
      if (hit) cpu_data <= hit_byte;
      if (state == CAPTURE && !we_q) begin
        if (sel_wb) wbs_dat_o <= sram_dout;
        else        cpu_data  <= lane_byte(sram_dout, lane_q);
      end
      // Buffer hits do not consume the SRAM, so they do not count against Wishbone.
      if (state == IDLE) begin
        if (!wb_pend || grant_wb)
          starve_cnt <= '0;
        else if (grant_cpu && !hit && starve_cnt != STARVE_MAX)
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural SRAM; optional fetch buffer via ROM_FETCH_CACHE_EN.
module tb_rom_port_arbiter;
  localparam int ADDR_W = 9;
`ifdef ROM_FETCH_CACHE_EN
  localparam int REP_LAT = 1;
`else
  localparam int REP_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cpu_req;
  logic [ADDR_W+1:0] cpu_addr;
  logic [7:0] cpu_data;
  logic cpu_valid;
  logic wbs_sel, wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [ADDR_W-1:0] wbs_adr_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic wbs_ack_o;
  logic sram_csb, sram_web;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0] sram_din, sram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.ADDR_W(ADDR_W), .WB_STARVE_MAX(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_valid(cpu_valid),
    .wbs_sel(wbs_sel), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  // SRAM model with a backdoor port for preloading
  logic [31:0] mem [0:511];
  logic bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      sram_dout <= mem[sram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick;
    bd_we = 1'b0;
  endtask

  task automatic do_fetch(input logic [ADDR_W+1:0] a, output int lat, output logic [7:0] d,
                          output bit csb_seen);
    cpu_req = 1'b1; cpu_addr = a; lat = -1; d = '0; csb_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (!sram_csb) csb_seen = 1'b1;
      if (cpu_valid) begin lat = c; d = cpu_data; break; end
    end
    cpu_req = 1'b0;
    tick;
  endtask

  task automatic do_wb(input logic we, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output bit web_seen);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_sel = 1'b1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = wd; lat = -1; rd = '0; web_seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (!sram_web) web_seen = 1'b1;
      if (wbs_ack_o) begin lat = c; rd = wbs_dat_o; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total += 8;
    if (cpu_valid !== 1'b0)     begin bad++; $display("FAIL rst_cpu_valid got=%b exp=0", cpu_valid); end
    if (cpu_data !== 8'h00)     begin bad++; $display("FAIL rst_cpu_data got=%h exp=00", cpu_data); end
    if (wbs_ack_o !== 1'b0)     begin bad++; $display("FAIL rst_ack got=%b exp=0", wbs_ack_o); end
    if (wbs_dat_o !== 32'h0)    begin bad++; $display("FAIL rst_wbs_dat got=%h exp=0", wbs_dat_o); end
    if (sram_csb !== 1'b1)      begin bad++; $display("FAIL rst_csb got=%b exp=1", sram_csb); end
    if (sram_web !== 1'b1)      begin bad++; $display("FAIL rst_web got=%b exp=1", sram_web); end
    if (sram_addr !== 9'h0)     begin bad++; $display("FAIL rst_sram_addr got=%h exp=0", sram_addr); end
    if (sram_din !== 32'h0)     begin bad++; $display("FAIL rst_sram_din got=%h exp=0", sram_din); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_cpu_fetch;
    logic [10:0] addrs [3] = '{11'h004, 11'h005, 11'h007};
    logic [7:0]  exps  [3] = '{8'hD4, 8'hC3, 8'hA1};
    int lat; logic [7:0] d; bit cs;
    preload(9'd1, 32'hA1B2C3D4);
    cpu_req = 1'b1; cpu_addr = 11'h006;
    tick;
    total += 3;
    if (sram_csb !== 1'b0)  begin bad++; $display("FAIL fetch_csb_t1 got=%b exp=0", sram_csb); end
    if (sram_addr !== 9'd1) begin bad++; $display("FAIL fetch_addr got=%h exp=1", sram_addr); end
    if (sram_web !== 1'b1)  begin bad++; $display("FAIL fetch_web got=%b exp=1", sram_web); end
    cpu_addr = 11'h000;  // must be ignored for the access in flight
    tick;
    total += 2;
    if (sram_csb !== 1'b1)  begin bad++; $display("FAIL fetch_csb_t2 got=%b exp=1", sram_csb); end
    if (cpu_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid_t2 got=%b exp=0", cpu_valid); end
    tick;
    total += 2;
    if (cpu_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid_t3 got=%b exp=1", cpu_valid); end
    if (cpu_data !== 8'hB2) begin bad++; $display("FAIL fetch_data got=%h exp=B2", cpu_data); end
    cpu_req = 1'b0;
    tick;
    total += 2;
    if (cpu_valid !== 1'b0) begin bad++; $display("FAIL fetch_valid_t4 got=%b exp=0", cpu_valid); end
    if (cpu_data !== 8'hB2) begin bad++; $display("FAIL fetch_data_hold got=%h exp=B2", cpu_data); end
    for (int i = 0; i < 3; i++) begin
      do_fetch(addrs[i], lat, d, cs);
      total += 2;
      if (lat !== REP_LAT) begin bad++; $display("FAIL lane%0d_lat got=%0d exp=%0d", i, lat, REP_LAT); end
      if (d !== exps[i])   begin bad++; $display("FAIL lane%0d_data got=%h exp=%h", i, d, exps[i]); end
    end
  endtask

  task automatic test_wb_write_read;
    int lat, n_ack, n_csb; logic [31:0] rd; bit ws;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_sel = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 9'd5; wbs_dat_i = 32'hDEADBEEF;
    tick;
    total += 4;
    if (sram_csb !== 1'b0)          begin bad++; $display("FAIL wr_csb got=%b exp=0", sram_csb); end
    if (sram_web !== 1'b0)          begin bad++; $display("FAIL wr_web got=%b exp=0", sram_web); end
    if (sram_addr !== 9'd5)         begin bad++; $display("FAIL wr_addr got=%h exp=5", sram_addr); end
    if (sram_din !== 32'hDEADBEEF)  begin bad++; $display("FAIL wr_din got=%h exp=DEADBEEF", sram_din); end
    tick;
    tick;
    total += 2;
    if (wbs_ack_o !== 1'b1) begin bad++; $display("FAIL wr_ack_t3 got=%b exp=1", wbs_ack_o); end
    if (cpu_valid !== 1'b0) begin bad++; $display("FAIL wr_cpu_valid got=%b exp=0", cpu_valid); end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    tick;
    total += 2;
    if (wbs_ack_o !== 1'b0)     begin bad++; $display("FAIL wr_ack_t4 got=%b exp=0", wbs_ack_o); end
    if (mem[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem got=%h exp=DEADBEEF", mem[5]); end
    do_wb(1'b0, 9'd5, 32'h0, lat, rd, ws);
    total += 4;
    if (lat !== 3)             begin bad++; $display("FAIL rd_lat got=%0d exp=3", lat); end
    if (rd !== 32'hDEADBEEF)   begin bad++; $display("FAIL rd_data got=%h exp=DEADBEEF", rd); end
    if (ws !== 1'b0)           begin bad++; $display("FAIL rd_web_low got=%b exp=0", ws); end
    if (wbs_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_hold got=%h exp=DEADBEEF", wbs_dat_o); end
    // Outside the program-memory region: no access
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_sel = 1'b0; n_ack = 0; n_csb = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (wbs_ack_o) n_ack++;
      if (!sram_csb) n_csb++;
    end
    total += 2;
    if (n_ack !== 0) begin bad++; $display("FAIL nosel_ack got=%0d exp=0", n_ack); end
    if (n_csb !== 0) begin bad++; $display("FAIL nosel_csb got=%0d exp=0", n_csb); end
    // Abort: cyc drops right after grant, ack still pulses exactly once
    wbs_sel = 1'b1; wbs_adr_i = 9'd5; n_ack = 0;
    tick;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (wbs_ack_o) n_ack++;
    end
    total += 1;
    if (n_ack !== 1) begin bad++; $display("FAIL abort_ack_count got=%0d exp=1", n_ack); end
  endtask

  task automatic test_simultaneous;
    int cpu_t, wb_t, both; logic [7:0] cd; logic [31:0] wd;
    preload(9'd3, 32'h0A0B0C0D);
    preload(9'd7, 32'h12345678);
    cpu_t = -1; wb_t = -1; both = 0; cd = '0; wd = '0;
    cpu_req = 1'b1; cpu_addr = 11'h00C;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_sel = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 9'd7;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (cpu_valid && wbs_ack_o) both++;
      if (cpu_valid && cpu_t < 0) begin cpu_t = c; cd = cpu_data; cpu_req = 1'b0; end
      if (wbs_ack_o && wb_t < 0) begin wb_t = c; wd = wbs_dat_o; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      if (cpu_t >= 0 && wb_t >= 0) break;
    end
    tick;
    total += 5;
    if (cpu_t !== 3)          begin bad++; $display("FAIL simul_cpu_t got=%0d exp=3", cpu_t); end
    if (wb_t !== 7)           begin bad++; $display("FAIL simul_wb_t got=%0d exp=7", wb_t); end
    if (cd !== 8'h0D)         begin bad++; $display("FAIL simul_cpu_data got=%h exp=0D", cd); end
    if (wd !== 32'h12345678)  begin bad++; $display("FAIL simul_wb_data got=%h exp=12345678", wd); end
    if (both !== 0)           begin bad++; $display("FAIL simul_both got=%0d exp=0", both); end
  endtask

  task automatic test_starvation;
    int n_before, wb_t, next_cpu, k, data_err, both;
    for (int i = 0; i < 6; i++) preload(9'(16 + i), {24'h0, 8'(8'h10 + i)});
    n_before = 0; wb_t = -1; next_cpu = -1; k = 0; data_err = 0; both = 0;
    cpu_req = 1'b1; cpu_addr = 11'h040;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_sel = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 9'd7;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (cpu_valid && wbs_ack_o) both++;
      if (cpu_valid) begin
        if (cpu_data !== 8'(8'h10 + k)) data_err++;
        k++;
        cpu_addr = cpu_addr + 11'd4;
        if (wb_t < 0) n_before++;
        else begin next_cpu = c; cpu_req = 1'b0; end
      end
      if (wbs_ack_o) begin
        wb_t = c;
        if (wbs_dat_o !== 32'h12345678) data_err++;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
      if (next_cpu >= 0) break;
    end
    tick;
    total += 5;
    if (n_before !== 4) begin bad++; $display("FAIL starve_cpu_before got=%0d exp=4", n_before); end
    if (wb_t !== 19)    begin bad++; $display("FAIL starve_ack_t got=%0d exp=19", wb_t); end
    if (next_cpu !== 23) begin bad++; $display("FAIL starve_resume_t got=%0d exp=23", next_cpu); end
    if (data_err !== 0) begin bad++; $display("FAIL starve_data_errs got=%0d exp=0", data_err); end
    if (both !== 0)     begin bad++; $display("FAIL starve_both got=%0d exp=0", both); end
  endtask

  task automatic test_reset_mid;
    int n_valid, lat; logic [7:0] d; bit cs;
    cpu_req = 1'b1; cpu_addr = 11'h00C;
    tick;
    tick;
    rst = 1'b1; cpu_req = 1'b0;
    tick;
    total += 5;
    if (cpu_valid !== 1'b0)  begin bad++; $display("FAIL midrst_valid got=%b exp=0", cpu_valid); end
    if (cpu_data !== 8'h00)  begin bad++; $display("FAIL midrst_data got=%h exp=00", cpu_data); end
    if (sram_csb !== 1'b1)   begin bad++; $display("FAIL midrst_csb got=%b exp=1", sram_csb); end
    if (sram_addr !== 9'h0)  begin bad++; $display("FAIL midrst_addr got=%h exp=0", sram_addr); end
    if (wbs_dat_o !== 32'h0) begin bad++; $display("FAIL midrst_wbs_dat got=%h exp=0", wbs_dat_o); end
    rst = 1'b0; n_valid = 0;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (cpu_valid) n_valid++;
    end
    do_fetch(11'h00E, lat, d, cs);
    total += 3;
    if (n_valid !== 0) begin bad++; $display("FAIL midrst_dropped got=%0d exp=0", n_valid); end
    if (lat !== 3)     begin bad++; $display("FAIL midrst_fresh_lat got=%0d exp=3", lat); end
    if (d !== 8'h0B)   begin bad++; $display("FAIL midrst_fresh_data got=%h exp=0B", d); end
  endtask

  task automatic test_fetch_buffer;
    int lat; logic [7:0] d; bit cs, ws; logic [31:0] rd;
    preload(9'd2, 32'h55667788);
    do_fetch(11'h008, lat, d, cs);
    total += 2;
    if (lat !== 3)   begin bad++; $display("FAIL buf_miss_lat got=%0d exp=3", lat); end
    if (d !== 8'h88) begin bad++; $display("FAIL buf_miss_data got=%h exp=88", d); end
    do_fetch(11'h009, lat, d, cs);
    total += 3;
    if (lat !== REP_LAT)          begin bad++; $display("FAIL buf_rep_lat got=%0d exp=%0d", lat, REP_LAT); end
    if (d !== 8'h77)              begin bad++; $display("FAIL buf_rep_data got=%h exp=77", d); end
    if (cs !== (REP_LAT == 3))    begin bad++; $display("FAIL buf_rep_csb_seen got=%b exp=%b", cs, REP_LAT == 3); end
    do_wb(1'b1, 9'd2, 32'hCAFEF00D, lat, rd, ws);
    total += 1;
    if (lat !== 3) begin bad++; $display("FAIL buf_wr_lat got=%0d exp=3", lat); end
    do_fetch(11'h00A, lat, d, cs);
    total += 3;
    if (lat !== 3)   begin bad++; $display("FAIL buf_inval_lat got=%0d exp=3", lat); end
    if (d !== 8'hFE) begin bad++; $display("FAIL buf_inval_data got=%h exp=FE", d); end
    if (cs !== 1'b1) begin bad++; $display("FAIL buf_inval_csb_seen got=%b exp=1", cs); end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
    wbs_sel = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    test_reset;
    test_cpu_fetch;
    test_wb_write_read;
    test_simultaneous;
    test_starvation;
    test_reset_mid;
    test_fetch_buffer;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
